// File: rtl/core_pkg.sv
// core_pkg: shared fetch-side state type and default sizes
package core_pkg;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_XLEN = 32;
  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} fetch_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO with synchronous flush
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp] <= wdata;
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: credit-limited instruction prefetch with redirect flush and stale-response drain
module ifetch_queue import core_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_enable,
  input  logic            redirect,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state, state_n;
  logic [CW-1:0] drop_cnt, drop_n, af_count, ib_count;
  logic [CW:0] inflight;
  logic [XLEN-1:0] af_head;
  logic [2*XLEN-1:0] ib_head;
  logic af_full, af_empty, ib_full, ib_empty, fire, rsp_take;
  assign inflight = {1'b0, ib_count} + {1'b0, af_count};
  assign imem_req_valid = !reset && state == RUN && !redirect && !af_full && !ib_full &&
                          inflight < (CW+1)'(DEPTH);
  assign fire = imem_req_valid && imem_req_ready;
  assign pc_enable = !reset && (fire || redirect);
  assign imem_req_addr = pc;
  assign rsp_take = state == RUN && imem_rsp_valid && !af_empty;
  assign dec_valid = !reset && !ib_empty;
  assign dec_pc = dec_valid ? ib_head[2*XLEN-1:XLEN] : '0;
  assign dec_instr = dec_valid ? ib_head[XLEN-1:0] : '0;
  // a response landing in the redirect cycle is already accounted for, so it is not drained later
  always_comb begin
    drop_n = drop_cnt;
    state_n = state;
    if (state == RUN) begin
      drop_n = redirect ? af_count - CW'(rsp_take) : '0;
      state_n = (redirect && drop_n != '0) ? FLUSH : RUN;
    end else begin
      drop_n = drop_cnt - CW'(imem_rsp_valid && drop_cnt != '0);
      state_n = drop_n == '0 ? RUN : FLUSH;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      drop_cnt <= drop_n;
    end
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_fifo (
    .clk(clk), .reset(reset), .flush(redirect),
    .push(fire), .pop(rsp_take), .wdata(pc), .rdata(af_head),
    .full(af_full), .empty(af_empty), .count(af_count)
  );
  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_buf (
    .clk(clk), .reset(reset), .flush(redirect),
    .push(rsp_take && !redirect), .pop(dec_valid && dec_ready),
    .wdata({af_head, imem_rsp_data}), .rdata(ib_head),
    .full(ib_full), .empty(ib_empty), .count(ib_count)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: table vectors, directed corner sequences and a queue-based reference model
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN = 32;
  logic clk = 0, reset = 1, pc_enable, redirect = 0, imem_req_valid, imem_req_ready = 0;
  logic imem_rsp_valid = 0, dec_valid, dec_ready = 0;
  logic [XLEN-1:0] pc = '0, imem_req_addr, imem_rsp_data = '0, dec_instr, dec_pc;
  always #5 clk = ~clk;
  ifetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_enable(pc_enable), .redirect(redirect),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
  );
  typedef struct {logic [31:0] addr; int t;} mreq_t;
  typedef struct {
    logic [31:0] pc; logic rd, rdy, rv; logic [31:0] data; logic drdy;
    logic ereq, epce, edv; logic [31:0] epc, einstr;
  } vec_t;
  int checks = 0, errors = 0, cyc = 0, lat = 1, mdrop = 0, dut_fires = 0;
  logic mflush = 0;
  logic [31:0] mpc = '0;
  logic [31:0] outq[$];
  logic [63:0] bufq[$];
  mreq_t memq[$];
  logic last_req, last_pce, last_dv;
  logic [31:0] last_dpc, last_din;
  function automatic logic [31:0] dfun(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic reset_cycle();
    @(negedge clk);
    reset = 1; redirect = 1; imem_req_ready = 1; imem_rsp_valid = 1; dec_ready = 1; pc = mpc;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
    chk("rst_pc_enable", 64'(pc_enable), 64'(0));
    chk("rst_dec_valid", 64'(dec_valid), 64'(0));
    chk("rst_dec_pc", 64'(dec_pc), 64'(0));
    chk("rst_dec_instr", 64'(dec_instr), 64'(0));
    @(posedge clk);
    mflush = 0; mdrop = 0; mpc = '0; cyc = 0;
    outq.delete(); bufq.delete(); memq.delete();
  endtask
  task automatic cycle(input logic rd, input logic [31:0] tgt, input logic rdy, input logic go, input logic drdy);
    logic rv, ereq, efire, epce, edv;
    logic [31:0] rdat;
    logic [63:0] head;
    @(negedge clk);
    rv = go && memq.size() > 0 && memq[0].t <= cyc;
    rdat = rv ? dfun(memq[0].addr) : '0;
    reset = 0; pc = mpc; redirect = rd; imem_req_ready = rdy;
    imem_rsp_valid = rv; imem_rsp_data = rdat; dec_ready = drdy;
    ereq = !mflush && (bufq.size() + outq.size() < DEPTH) && !rd;
    efire = ereq && rdy;
    epce = efire || rd;
    edv = bufq.size() > 0;
    head = '0;
    if (edv) head = bufq[0];
    #1;
    chk("req_valid", 64'(imem_req_valid), 64'(ereq));
    chk("pc_enable", 64'(pc_enable), 64'(epce));
    chk("req_addr", 64'(imem_req_addr), 64'(mpc));
    chk("dec_valid", 64'(dec_valid), 64'(edv));
    chk("dec_pc", 64'(dec_pc), 64'(head[63:32]));
    chk("dec_instr", 64'(dec_instr), 64'(head[31:0]));
    last_req = imem_req_valid; last_pce = pc_enable; last_dv = dec_valid;
    last_dpc = dec_pc; last_din = dec_instr;
    if (imem_req_valid && imem_req_ready) dut_fires++;
    @(posedge clk);
    if (rv) void'(memq.pop_front());
    if (efire) memq.push_back('{mpc, cyc + lat});
    if (!mflush) begin
      if (rd) begin
        mdrop = outq.size() - int'(rv);
        outq.delete(); bufq.delete();
        mflush = mdrop > 0;
      end else begin
        if (edv && drdy) void'(bufq.pop_front());
        if (rv) bufq.push_back({outq.pop_front(), rdat});
        if (efire) outq.push_back(mpc);
      end
    end else begin
      if (rv && mdrop > 0) mdrop--;
      mflush = mdrop > 0;
    end
    if (epce) mpc = rd ? tgt : mpc + 1;
    cyc++;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl[7];
    bit seen;
    tbl[0] = '{32'd0, 0, 1, 0, 32'h0,         1, 1, 1, 0, 32'd0, 32'h0};
    tbl[1] = '{32'd1, 0, 1, 1, 32'hA000_0000, 1, 1, 1, 0, 32'd0, 32'h0};
    tbl[2] = '{32'd2, 0, 1, 1, 32'hA000_0001, 1, 1, 1, 1, 32'd0, 32'hA000_0000};
    tbl[3] = '{32'd3, 0, 0, 1, 32'hA000_0002, 1, 1, 0, 1, 32'd1, 32'hA000_0001};
    tbl[4] = '{32'd3, 0, 1, 0, 32'h0,         1, 1, 1, 1, 32'd2, 32'hA000_0002};
    tbl[5] = '{32'd4, 0, 1, 1, 32'hA000_0003, 1, 1, 1, 0, 32'd0, 32'h0};
    tbl[6] = '{32'd5, 0, 0, 0, 32'h0,         1, 1, 0, 1, 32'd3, 32'hA000_0003};
    reset_cycle();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      reset = 0; pc = tbl[i].pc; redirect = tbl[i].rd; imem_req_ready = tbl[i].rdy;
      imem_rsp_valid = tbl[i].rv; imem_rsp_data = tbl[i].data; dec_ready = tbl[i].drdy;
      #1;
      chk($sformatf("tbl%0d_req_valid", i), 64'(imem_req_valid), 64'(tbl[i].ereq));
      chk($sformatf("tbl%0d_pc_enable", i), 64'(pc_enable), 64'(tbl[i].epce));
      chk($sformatf("tbl%0d_dec_valid", i), 64'(dec_valid), 64'(tbl[i].edv));
      chk($sformatf("tbl%0d_dec_pc", i), 64'(dec_pc), 64'(tbl[i].epc));
      chk($sformatf("tbl%0d_dec_instr", i), 64'(dec_instr), 64'(tbl[i].einstr));
    end
    // decode stalled: credit stops fetch after exactly DEPTH requests
    reset_cycle();
    lat = 1; dut_fires = 0;
    for (int i = 0; i < 10; i++) cycle(0, '0, 1, 1, 0);
    chk("stall_fires", 64'(dut_fires), 64'(4));
    chk("stall_req_valid", 64'(last_req), 64'(0));
    chk("stall_pc_enable", 64'(last_pce), 64'(0));
    // redirect with three outstanding: drain them, then deliver the target
    reset_cycle();
    lat = 6;
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 1);
    cycle(1, 32'h100, 1, 0, 1);
    lat = 1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle(0, '0, 1, 1, 1);
      if (last_dv) begin
        seen = 1;
        chk("redir_first_pc", 64'(last_dpc), 64'h100);
        chk("redir_first_instr", 64'(last_din), 64'(dfun(32'h100)));
      end
    end
    if (!seen) chk("redir_first_timeout", 64'(0), 64'(1));
    // redirect coinciding with the only response: no drain state
    reset_cycle();
    lat = 1;
    cycle(0, '0, 1, 1, 0);
    cycle(1, 32'h40, 1, 1, 0);
    cycle(0, '0, 1, 1, 0);
    chk("same_cycle_req_valid", 64'(last_req), 64'(1));
    chk("same_cycle_dec_valid", 64'(last_dv), 64'(0));
    // memory back-pressure: counter holds, nothing lost
    reset_cycle();
    lat = 2;
    cycle(0, '0, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 0, 1, 1);
      chk("bp_pc_enable", 64'(last_pce), 64'(0));
      chk("bp_req_addr", 64'(imem_req_addr), 64'(1));
    end
    for (int i = 0; i < 8; i++) cycle(0, '0, 1, 1, 1);
    // reset in the middle of a drain
    reset_cycle();
    lat = 10;
    cycle(0, '0, 1, 0, 1);
    cycle(0, '0, 1, 0, 1);
    cycle(1, 32'h200, 1, 0, 1);
    cycle(0, '0, 1, 0, 1);
    chk("flush_req_valid", 64'(last_req), 64'(0));
    reset_cycle();
    cycle(0, '0, 1, 0, 1);
    chk("post_rst_req_valid", 64'(last_req), 64'(1));
    chk("post_rst_dec_valid", 64'(last_dv), 64'(0));
    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) reset_cycle();
      else begin
        lat = $urandom_range(1, 4);
        cycle($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction-buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, address and instruction width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pc, input, XLEN, the current program counter value.
REQ-006 SHALL have port pc_enable, output, 1, enable to the program counter; high advances it by 1 or loads the redirect address.
REQ-007 SHALL have port redirect, input, 1, branch/jump redirect (same cycle as the counter's preset).
REQ-008 SHALL have port imem_req_valid, output, 1, instruction-memory read request.
REQ-009 SHALL have port imem_req_ready, input, 1, memory accepts the request this cycle.
REQ-010 SHALL have port imem_req_addr, output, XLEN, read address, equal to pc.
REQ-011 SHALL have port imem_rsp_valid, input, 1, in-order read data valid.
REQ-012 SHALL have port imem_rsp_data, input, XLEN, returned instruction word.
REQ-013 SHALL have port dec_valid, output, 1, instruction available to decode.
REQ-014 SHALL have port dec_ready, input, 1, decode accepts the instruction.
REQ-015 SHALL have port dec_instr, output, XLEN, head instruction.
REQ-016 SHALL have port dec_pc, output, XLEN, address of the head instruction.

Function
REQ-017 SHALL issue a request (fire) only when imem_req_valid && imem_req_ready.
REQ-018 SHALL assert imem_req_valid in state RUN when occupancy + outstanding < DEPTH and redirect is low.
REQ-019 SHALL drive pc_enable = fire || redirect, combinationally, so the counter advances exactly once per fire and always samples the redirect.
REQ-020 SHALL push the pc of every fired request into an outstanding-address FIFO (DEPTH entries).
REQ-021 SHALL treat responses as in-order; memory latency is >= 1 cycle and unbounded.
REQ-022 SHALL, on a non-stale response, write {outstanding-FIFO head pc, imem_rsp_data} into the instruction buffer and pop the address FIFO, in the same cycle.
REQ-023 SHALL present the buffer head on dec_valid/dec_instr/dec_pc; it pops on dec_valid && dec_ready.
REQ-024 SHALL support simultaneous buffer push and pop in one cycle with occupancy unchanged.
REQ-025 SHALL implement states RUN and FLUSH.
REQ-026 SHALL, in RUN on redirect, flush the instruction buffer (dec_valid low next cycle), set drop_cnt = outstanding (minus 1 if a response arrives that same cycle), clear the address FIFO, and go to FLUSH if drop_cnt > 0, else stay in RUN.
REQ-027 SHALL, in FLUSH, hold imem_req_valid low, discard each response while decrementing drop_cnt, and return to RUN the cycle after drop_cnt reaches 0.
REQ-028 SHALL, on redirect during FLUSH, keep draining with the current drop_cnt (no new outstanding exist).
REQ-029 SHALL ignore dec_ready in the redirect cycle; a head instruction that is popped that cycle still counts as delivered.
REQ-030 SHALL never overflow: the credit rule guarantees occupancy + outstanding <= DEPTH, wrapping pointers modulo DEPTH.

Reset
REQ-031 SHALL, when reset is high at a clock edge, enter RUN and clear occupancy, outstanding, drop_cnt and all pointers.
REQ-032 SHALL hold outputs during reset at imem_req_valid=0, pc_enable=0, dec_valid=0, dec_instr=0, dec_pc=0, with reset dominating redirect and all handshakes.
REQ-033 SHALL drop responses for requests issued before reset; the system resets memory in the same cycle.

Structure
REQ-034 SHALL place the state enum (RUN, FLUSH) and the default DEPTH/XLEN constants in shared package core_pkg.
REQ-035 SHALL instantiate sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count; synchronous flush) twice: once for the address FIFO and once for the instruction buffer with WIDTH = 2*XLEN.

Verification
REQ-036 Reset then ready=1, rsp 1 cycle later, dec_ready=1, pc 0,1,2 -> dec_pc 0,1,2 with matching data, one instruction per cycle after 2-cycle fill.
REQ-037 dec_ready=0, memory always ready -> exactly 4 requests, then imem_req_valid=0 and pc_enable=0; pc holds at 4.
REQ-038 Redirect with 3 outstanding, target 0x100 -> next 3 responses dropped, no request during FLUSH, first dec_pc after that = 0x100.
REQ-039 Redirect in the same cycle as a response with 1 outstanding -> no FLUSH entered, dec_valid low next cycle.
REQ-040 imem_req_ready low for 5 cycles -> pc_enable low and pc unchanged for those cycles; no request lost.
REQ-041 Reset asserted while in FLUSH with drop_cnt=2 -> RUN, all outputs at reset values on the next cycle.
